// File: rtl/pool_pair_feeder_pkg.sv
// Shared types for the pool pair feeder and its MaxPool2d consumer.
// Holds the row-phase state encoding and the pixel word type.
package pool_pair_feeder_pkg;

   localparam int WORDLENGTH = 16;

   typedef logic signed [WORDLENGTH-1:0] pixel_t;

   typedef enum logic {
      FILL = 1'b0,
      PAIR = 1'b1
   } state_t;

endpackage : pool_pair_feeder_pkg

// File: rtl/pool_line_buffer.sv
// One-row pixel store: a single write port and a combinational read port.
// Contents are not reset; every word is written during a row before it is read.
module pool_line_buffer #(
   parameter int depth      = 28,
   parameter int width      = 16,
   parameter int addr_width = 5
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [addr_width-1:0]   wr_addr,
   input  logic signed [width-1:0] wr_data,
   input  logic [addr_width-1:0]   rd_addr,
   output logic signed [width-1:0] rd_data
);

   logic signed [width-1:0] mem_r [depth];

   // Store the upper-row pixel at its column.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule : pool_line_buffer

// File: rtl/pool_pair_feeder.sv
// Buffers each even row and, during the following odd row, emits vertical
// pixel pairs (upper, lower) for the 2x2 max-pool stage.
module pool_pair_feeder
   import pool_pair_feeder_pkg::*;
#(
   parameter int dataColNum = 28,
   parameter int dataRowNum = 28,
   parameter int wordlength = 16,
   parameter int col_length = 5
) (
   input  logic                         clk,
   input  logic                         irst_n,
   input  logic                         in_valid,
   input  logic signed [wordlength-1:0] pixel_in,
   input  logic                         clear,
   output logic signed [wordlength-1:0] pixels_0,
   output logic signed [wordlength-1:0] pixels_1,
   output logic                         out_valid,
   output logic                         frame_done
);

   generate
      if (((dataColNum % 2) != 0) || ((dataRowNum % 2) != 0)) begin : g_odd_geometry
         $error("pool_pair_feeder: dataColNum and dataRowNum must both be even");
      end
      if (((2 ** col_length) < dataColNum) || ((2 ** col_length) < dataRowNum)) begin : g_narrow_counter
         $error("pool_pair_feeder: col_length too small for the frame geometry");
      end
   endgenerate

   state_t                       state_r, state_s;
   logic [col_length-1:0]        col_cnt_r, col_cnt_s;
   logic [col_length-1:0]        row_cnt_r, row_cnt_s;
   logic signed [wordlength-1:0] pixels_0_r, pixels_0_s;
   logic signed [wordlength-1:0] pixels_1_r, pixels_1_s;
   logic                         out_valid_r, out_valid_s;
   logic                         frame_done_r, frame_done_s;
   logic                         wr_en_s;
   logic                         col_last_s, row_last_s;
   logic signed [wordlength-1:0] rd_data_s;

   assign col_last_s = (col_cnt_r == col_length'(dataColNum - 1));
   assign row_last_s = (row_cnt_r == col_length'(dataRowNum - 1));

   pool_line_buffer #(
      .depth      (dataColNum),
      .width      (wordlength),
      .addr_width (col_length)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (col_cnt_r),
      .wr_data (pixel_in),
      .rd_addr (col_cnt_r),
      .rd_data (rd_data_s)
   );

   // Next-state, counter and output-pair decode; clear outranks in_valid.
   always_comb begin
      state_s      = state_r;
      col_cnt_s    = col_cnt_r;
      row_cnt_s    = row_cnt_r;
      pixels_0_s   = pixels_0_r;
      pixels_1_s   = pixels_1_r;
      out_valid_s  = 1'b0;
      frame_done_s = 1'b0;
      wr_en_s      = 1'b0;
      if (clear) begin
         state_s   = FILL;
         col_cnt_s = {col_length{1'b0}};
         row_cnt_s = {col_length{1'b0}};
      end else if (in_valid) begin
         case (state_r)
            FILL: begin
               wr_en_s = 1'b1;
            end
            PAIR: begin
               pixels_0_s   = rd_data_s;
               pixels_1_s   = pixel_in;
               out_valid_s  = 1'b1;
               frame_done_s = col_last_s && row_last_s;
            end
            default: begin
               wr_en_s = 1'b0;
            end
         endcase
         if (col_last_s) begin
            col_cnt_s = {col_length{1'b0}};
            state_s   = (state_r == FILL) ? PAIR : FILL;
            if (row_last_s) begin
               row_cnt_s = {col_length{1'b0}};
            end else begin
               row_cnt_s = row_cnt_r + col_length'(1);
            end
         end else begin
            col_cnt_s = col_cnt_r + col_length'(1);
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge irst_n) begin
      if (!irst_n) begin
         state_r      <= FILL;
         col_cnt_r    <= {col_length{1'b0}};
         row_cnt_r    <= {col_length{1'b0}};
         pixels_0_r   <= {wordlength{1'b0}};
         pixels_1_r   <= {wordlength{1'b0}};
         out_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         col_cnt_r    <= col_cnt_s;
         row_cnt_r    <= row_cnt_s;
         pixels_0_r   <= pixels_0_s;
         pixels_1_r   <= pixels_1_s;
         out_valid_r  <= out_valid_s;
         frame_done_r <= frame_done_s;
      end
   end

   assign pixels_0   = pixels_0_r;
   assign pixels_1   = pixels_1_r;
   assign out_valid  = out_valid_r;
   assign frame_done = frame_done_r;

endmodule : pool_pair_feeder

// File: tb/tb_pool_pair_feeder.sv
// Scoreboard bench for pool_pair_feeder on a 4x4 frame: a frame-position model
// queues expected pairs, a negedge monitor pops and compares them.
module tb_pool_pair_feeder;

   localparam int C  = 4;
   localparam int R  = 4;
   localparam int W  = 16;
   localparam int CL = 3;

   logic                clk;
   logic                irst_n;
   logic                in_valid;
   logic signed [W-1:0] pixel_in;
   logic                clear;
   logic signed [W-1:0] pixels_0;
   logic signed [W-1:0] pixels_1;
   logic                out_valid;
   logic                frame_done;

   pool_pair_feeder #(
      .dataColNum (C),
      .dataRowNum (R),
      .wordlength (W),
      .col_length (CL)
   ) dut (
      .clk        (clk),
      .irst_n     (irst_n),
      .in_valid   (in_valid),
      .pixel_in   (pixel_in),
      .clear      (clear),
      .pixels_0   (pixels_0),
      .pixels_1   (pixels_1),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [W-1:0] p0;
      logic signed [W-1:0] p1;
      logic                fd;
   } exp_t;

   exp_t                exp_q[$];
   logic signed [W-1:0] upper[C];
   int                  pos;
   int                  n_checks;
   int                  n_fail;
   int                  fd_seen;
   logic signed [W-1:0] last_p0;
   logic signed [W-1:0] last_p1;

   task automatic check(input string name, input longint got, input longint want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Accepted pixel: locate it in the frame, remember upper rows, queue lower-row pairs.
   task automatic send(input logic signed [W-1:0] d);
      int row;
      int col;
      @(posedge clk); #1;
      in_valid = 1'b1;
      clear    = 1'b0;
      pixel_in = d;
      row = pos / C;
      col = pos % C;
      if ((row % 2) == 0) begin
         upper[col] = d;
      end else begin
         exp_q.push_back('{p0: upper[col], p1: d, fd: (pos == C * R - 1)});
      end
      pos = (pos + 1) % (C * R);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         clear    = 1'b0;
         pixel_in = W'($urandom);
      end
   endtask

   // Clear with a live pixel alongside: the pixel must be discarded.
   task automatic do_clear();
      @(posedge clk); #1;
      in_valid = 1'b1;
      clear    = 1'b1;
      pixel_in = W'($urandom);
      pos      = 0;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      irst_n   = 1'b0;
      exp_q.delete();
      pos = 0;
      repeat (n) @(posedge clk);
      #1;
      irst_n = 1'b1;
   endtask

   task automatic frame_seq(input int base, input bit gaps);
      for (int i = 0; i < C * R; i++) begin
         send(W'(base + i));
         if (gaps) idle(1);
      end
   endtask

   // Monitor: pop and compare on every valid pair, check holds on idle cycles.
   always @(negedge clk) begin
      exp_t e;
      if (!irst_n) begin
         check("reset_out_valid", out_valid, 0);
         check("reset_frame_done", frame_done, 0);
         check("reset_pixels_0", pixels_0, 0);
         check("reset_pixels_1", pixels_1, 0);
         last_p0 = '0;
         last_p1 = '0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pixels_0", pixels_0, e.p0);
            check("pixels_1", pixels_1, e.p1);
            check("frame_done", frame_done, e.fd);
            if (frame_done) fd_seen++;
         end
         last_p0 = pixels_0;
         last_p1 = pixels_1;
      end else begin
         check("idle_frame_done", frame_done, 0);
         check("hold_pixels_0", pixels_0, last_p0);
         check("hold_pixels_1", pixels_1, last_p1);
      end
   end

   initial begin
      int fd_base;
      n_checks = 0;
      n_fail   = 0;
      fd_seen  = 0;
      pos      = 0;
      last_p0  = '0;
      last_p1  = '0;
      irst_n   = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      pixel_in = '0;
      repeat (3) @(posedge clk);
      #1;
      irst_n = 1'b1;
      idle(2);

      // Back-to-back frame, then the same frame with a gap after every pixel.
      frame_seq(0, 1'b0);
      idle(2);
      frame_seq(0, 1'b1);
      idle(2);

      // Signed extremes in rows 0 and 1.
      send(-16'sd1); send(-16'sd32768); send(16'sd5); send(16'sd0);
      send(16'sd3); send(-16'sd2); send(-16'sd7); send(16'sd32767);
      for (int i = 0; i < 2 * C; i++) send(W'($urandom));
      idle(2);

      // Two frames back-to-back: exactly two frame_done pulses.
      fd_base = fd_seen;
      frame_seq(0, 1'b0);
      frame_seq(100, 1'b0);
      idle(2);
      check("frame_done_count", fd_seen - fd_base, 2);

      // Reset mid-frame, then a full frame.
      for (int i = 0; i < 6; i++) send(W'(i));
      do_reset(3);
      frame_seq(0, 1'b0);
      idle(2);

      // Clear after pixel 5, then a full frame.
      for (int i = 0; i < 6; i++) send(W'(i));
      do_clear();
      frame_seq(0, 1'b0);
      idle(2);

      // Random traffic with random gaps and occasional clears.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 39) == 0) do_clear();
         else if ($urandom_range(0, 2) == 0) idle(1);
         else send(W'($urandom));
      end
      idle(4);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pool_pair_feeder

// File: doc/pool_pair_feeder.md
Name: pool_pair_feeder

Overview:
Producer side of the 2x2 max-pool interface. It accepts a raster-order pixel stream, one pixel per cycle, from the conv/ReLU stage. It buffers each even row in a line buffer. During the following odd row it emits vertical pixel pairs (pixels_0 = upper row, pixels_1 = lower row) with out_valid, in the column order the pooling block consumes. It sits directly between the conv output and MaxPool2d in the CNN datapath.

Parameters:
dataColNum, 28, pixels per row; must be even.
dataRowNum, 28, rows per frame; must be even.
wordlength, 16, signed pixel width.
col_length, 5, column/row counter width; 2^col_length >= max(dataColNum, dataRowNum).

Ports:
clk  input  1  clock, rising edge.
irst_n  input  1  asynchronous active-low reset.
in_valid  input  1  pixel_in valid this cycle.
pixel_in  input  wordlength  signed raster pixel.
clear  input  1  synchronous frame restart.
pixels_0  output  wordlength  signed upper-row pixel (row 2r, column c).
pixels_1  output  wordlength  signed lower-row pixel (row 2r+1, column c).
out_valid  output  1  pair valid; drives MaxPool2d in_valid.
frame_done  output  1  one-cycle pulse with the last pair of a frame.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (irst_n). On reset:
  - pixels_0 = 0, pixels_1 = 0, out_valid = 0, frame_done = 0.
  - col_cnt = 0, row_cnt = 0, state = FILL.
  - Line buffer contents are don't-care and are not reset.
- States:
  - FILL (even row): each in_valid writes pixel_in to linebuf[col_cnt]; out_valid = 0.
  - PAIR (odd row): each in_valid registers pixels_0 <= linebuf[col_cnt] and pixels_1 <= pixel_in, with out_valid = 1 on the next cycle.
- Latency: 1 cycle from an accepted odd-row pixel to its out_valid pair.
- Counters and state:
  - col_cnt increments on each in_valid and wraps from dataColNum-1 to 0.
  - On that wrap, row_cnt increments and state toggles FILL <-> PAIR.
  - row_cnt wraps from dataRowNum-1 to 0, so the next frame starts in FILL.
- No in_valid in a cycle: counters hold, out_valid = 0, pixels_0/pixels_1 hold their last values. Gaps of any length are legal.
- Pair ordering: pairs for columns 2k and 2k+1 are always emitted in that order. Because dataColNum is even, the downstream pool counter stays aligned to column pairs across row boundaries.
- frame_done = 1 in the same cycle as the out_valid for (row dataRowNum-1, column dataColNum-1); otherwise 0.
- clear:
  - Next cycle: col_cnt = 0, row_cnt = 0, state = FILL, out_valid = 0, frame_done = 0.
  - pixel_in in a cycle where clear is high is discarded.
  - clear has priority over in_valid.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The partial frame is lost and the next accepted pixel is treated as row 0, column 0.
- Line buffer:
  - dataColNum x wordlength register array with combinational read at col_cnt.
  - In PAIR, a column's read and its overwrite by the next frame can never collide, since FILL and PAIR alternate per row.
- No backpressure: the downstream pool always accepts.
- Elaboration checks: dataColNum or dataRowNum odd -> elaboration error.
- Arithmetic: pixels pass through unmodified; sign is preserved; no width change.

Decomposition:
- Shared package holds:
  - State encoding constants FILL = 1'b0 and PAIR = 1'b1.
  - Pixel word type of width wordlength, shared with MaxPool2d.
- Sub-module pool_line_buffer (dataColNum-deep register array, one write port, one combinational read port) is natural.
- Counter/FSM logic stays in pool_pair_feeder.

Test Plan:
- Config dataColNum = 4, dataRowNum = 4; feed pixels 0..15 back-to-back -> pairs (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15), each 1 cycle after its odd-row pixel. frame_done only with (11,15). No out_valid during rows 0 and 2.
- Same frame with in_valid low every other cycle -> identical pair sequence. out_valid low in gap cycles. pixels_0/pixels_1 held during gaps.
- Signed values: row 0 = -1, -32768, 5, 0 and row 1 = 3, -2, -7, 32767 -> pairs (-1,3),(-32768,-2),(5,-7),(0,32767) with exact bit patterns. Pooled through MaxPool2d -> 3, then 32767.
- Two back-to-back frames 0..15 and 100..115 -> the second frame's pairs start with (100,104). frame_done pulses exactly twice.
- Assert irst_n low after 6 pixels, release, feed 0..15 -> outputs 0 during reset and the normal full-frame sequence afterwards.
- Assert clear after pixel 5 (row 1, column 1), then feed 0..15 -> no further pair from the aborted frame. Full correct sequence follows, with (0,4) first.
